// File: rtl/instr_imm_decode_reg_if.sv
// ============================================================================
// Module      : instr_imm_decode_reg_if
// Description : Fetch-side and extender-side handshake bundle for the
//               instruction immediate decode register.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface instr_imm_decode_reg_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic        ext_enable;
    logic [15:0] count;

    // master: fetch/extender side driving words in and accepting decodes
    modport master (
        output in_valid,
        output instr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  opcode,
        input  rd,
        input  rs,
        input  imm,
        input  ext_enable,
        input  count
    );

    modport slave (
        input  in_valid,
        input  instr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output opcode,
        output rd,
        output rs,
        output imm,
        output ext_enable,
        output count
    );
endinterface

`default_nettype wire

// File: rtl/instr_imm_decode_reg.sv
// ============================================================================
// Module      : instr_imm_decode_reg
// Description : Two-entry skid pipeline register that decodes opcode, register
//               fields and the zero-extender immediate/enable for its head word.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_imm_decode_reg #(
    parameter logic [3:0] IMM8_LO  = 4'h8,
    parameter logic [3:0] IMM8_HI  = 4'hB,
    parameter logic [3:0] IMM12_OP = 4'hC
) (
    input  wire logic           clk,
    input  wire logic           reset,
    instr_imm_decode_reg_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t      state_q;
    logic        out_valid_q;
    logic        in_ready_q;
    logic [15:0] skid_q;
    logic [3:0]  opcode_q;
    logic [3:0]  rd_q;
    logic [3:0]  rs_q;
    logic [15:0] imm_q;
    logic        ext_enable_q;
    logic [15:0] count_q;
    logic [15:0] count_d;

    logic        w_in_xfer;
    logic        w_out_xfer;
    logic        w_head_load;
    logic [15:0] w_load_word;
    logic [15:0] w_load_imm;
    logic        w_load_en;

    assign w_in_xfer  = bus.in_valid && in_ready_q;
    assign w_out_xfer = out_valid_q && bus.out_ready;
    assign count_d    = count_q + 16'd1;

    // Head is refilled from skid when draining TWO, otherwise from the input.
    assign w_load_word = (state_q == ST_TWO) ? skid_q : bus.instr;

    always_comb begin
        w_head_load = 1'b0;
        case (state_q)
            ST_EMPTY: w_head_load = w_in_xfer;
            ST_ONE:   w_head_load = w_in_xfer && w_out_xfer;
            ST_TWO:   w_head_load = w_out_xfer;
            default:  w_head_load = 1'b0;
        endcase
    end

    always_comb begin
        w_load_imm = 16'h0000;
        w_load_en  = 1'b0;
        if ((w_load_word[15:12] >= IMM8_LO) && (w_load_word[15:12] <= IMM8_HI)) begin
            w_load_imm = {8'h00, w_load_word[7:0]};
            w_load_en  = 1'b1;
        end else if (w_load_word[15:12] == IMM12_OP) begin
            w_load_imm = {4'h0, w_load_word[11:0]};
            w_load_en  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            skid_q       <= 16'h0000;
            opcode_q     <= 4'h0;
            rd_q         <= 4'h0;
            rs_q         <= 4'h0;
            imm_q        <= 16'h0000;
            ext_enable_q <= 1'b0;
            count_q      <= 16'h0000;
        end else begin
            if (w_out_xfer) begin
                count_q <= count_d;
            end

            case (state_q)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        state_q     <= ST_ONE;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_out_xfer && !w_in_xfer) begin
                        state_q     <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else if (w_in_xfer && !w_out_xfer) begin
                        state_q     <= ST_TWO;
                        skid_q      <= bus.instr;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (w_out_xfer) begin
                        state_q     <= ST_ONE;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase

            // Decoded fields only move with the head, so they hold while idle.
            if (w_head_load) begin
                opcode_q     <= w_load_word[15:12];
                rd_q         <= w_load_word[11:8];
                rs_q         <= w_load_word[7:4];
                imm_q        <= w_load_imm;
                ext_enable_q <= w_load_en;
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.opcode     = opcode_q;
    assign bus.rd         = rd_q;
    assign bus.rs         = rs_q;
    assign bus.imm        = imm_q;
    assign bus.ext_enable = ext_enable_q;
    assign bus.count      = count_q;

endmodule

`default_nettype wire
